multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 4-bit-opcode datapath (ADD/ADDI/SUB/AND/OR/LW/SW/NOP).
//  Replaces single-cycle decode with an FSM that shares one memory port between fetch and load/store.
//  Drives the datapath strobes (IR/PC write, ALU src/op, reg dst/write, mem-to-reg) one phase at a time.
//  Handshakes with memory via req/ready and traps illegal opcodes and memory timeouts.
// PARAMETERS
//  WAIT_MAX  15  max ready-low cycles tolerated per memory access; 0 disables timeout
// PORTS
//  clk          in   1  clock, all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   4  IR[15:12]; sampled only in DECODE
//  mem_ready    in   1  memory completes access this cycle; ignored while mem_req=0
//  mem_req      out  1  memory access request, held until mem_ready
//  mem_we       out  1  1=write (SW data phase), 0=read
//  mem_sel      out  1  address mux: 0=PC (fetch), 1=ALU result (LW/SW)
//  ir_write     out  1  load IR from memory read data
//  pc_write     out  1  PC <= PC+1
//  alu_src      out  1  0=register B, 1=sign-extended immediate
//  alu_op       out  5  00010 add, 01110 sub, 00000 and, 00001 or
//  reg_dst      out  1  1=rd field, 0=rt field
//  reg_write    out  1  register file write strobe
//  mem_to_reg   out  1  1=writeback from memory data, 0=ALU result
//  instr_done   out  1  1-cycle pulse when an instruction retires
//  fault        out  1  sticky: illegal opcode or memory timeout
//  state        out  3  FSM state encoding, for debug and bench
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5. Codes 6/7 are unreachable and go to FAULT.
//  Reset: while rst=1, every output is 0, state=FETCH, op_q=0, wait_cnt=0.
//   The first cycle after release is FETCH with mem_req=1. rst mid-instruction aborts it; no strobe fires.
//  Outputs are combinational from registered state/op_q/mem_ready. Every output not listed for a state is 0 (never x).
//  FETCH: mem_req=1, mem_sel=0, mem_we=0.
//   On mem_ready: ir_write=1 and pc_write=1 in that same cycle, then -> DECODE. Otherwise stay.
//  DECODE: op_q <= opcode.
//   0000 NOP: instr_done=1, -> FETCH.
//   0001-0101, 1000, 1001: -> EXEC.
//   Any other opcode: -> FAULT.
//  EXEC (uses op_q): alu_op per opcode; LW/SW use add.
//   alu_src=1 for ADDI/LW/SW, else 0.
//   ALU ops (ADD/ADDI/SUB/AND/OR) -> WB; LW/SW -> MEM.
//  MEM: mem_req=1, mem_sel=1, mem_we=(op_q==SW); alu_op/alu_src are held from EXEC.
//   On mem_ready: SW -> instr_done=1, -> FETCH; LW -> WB. Otherwise stay.
//  WB: reg_write=1, instr_done=1, alu_op/alu_src held.
//   reg_dst=1 for ADD/SUB/AND/OR, 0 for ADDI/LW.
//   mem_to_reg=1 for LW, else 0. Then -> FETCH.
//  FAULT: fault=1, all other outputs 0. Exit only through rst.
//  Timeout: wait_cnt clears on entry to FETCH/MEM and increments each cycle with mem_req=1 and mem_ready=0.
//   When wait_cnt==WAIT_MAX and mem_ready=0 -> FAULT.
//   Net effect: mem_req is high for at most WAIT_MAX+1 cycles. wait_cnt saturates and has width $clog2(WAIT_MAX+1), minimum 1.
//   mem_ready=1 in the limit cycle wins: normal completion, no fault.
//  Latency with zero-wait memory: NOP 2, ADD/ADDI/SUB/AND/OR 4, SW 4, LW 5 cycles; each memory wait adds 1.
//  Back-to-back instructions: FETCH directly follows the retire cycle, with no idle cycle.
// TESTING
//  1 rst=1 for 3 cycles, mem_ready=1 -> all outputs 0 each cycle; first cycle after release: state=0, mem_req=1.
//  2 opcode=0001, mem_ready=1 -> states 0,1,2,4 in 4 cycles.
//    ir_write/pc_write only in cycle 0; alu_op=00010; reg_dst=1 and reg_write=1 only in WB; instr_done in WB.
//  3 opcode=1000, mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles with mem_req=1, mem_sel=1, mem_we=0.
//    Then WB with mem_to_reg=1, reg_dst=0, alu_src=1; 7 cycles total.
//  4 opcode=1001 -> MEM with mem_we=1; instr_done in the MEM ready cycle; reg_write never 1; next state FETCH.
//  5 opcode=0111 -> FAULT after DECODE; fault=1, mem_req=0 held 20 cycles; rst clears fault and restarts in FETCH.
//  6 WAIT_MAX=4, mem_ready=0 -> mem_req high exactly 5 cycles, then FAULT.
//    Repeat with mem_ready=1 on the 5th cycle -> DECODE, no fault.
//    Also assert rst during MEM of an LW -> no reg_write, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 4-bit-opcode datapath. One memory port is shared
// between instruction fetch and LW/SW, and illegal opcodes or stalled memory trap to FAULT.
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       alu_src,
    output logic [4:0] alu_op,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       fault,
    output logic [2:0] state
);

    localparam int unsigned   CW         = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01110;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    op_q;
    logic [CW-1:0] wait_cnt;
    logic          timeout;
    logic [4:0]    op_alu;
    logic          op_imm;
    logic          op_mem;

    // Datapath controls derived from the latched opcode, shared by EXEC/MEM/WB.
    always_comb begin
        case (op_q)
            OP_SUB:  op_alu = ALU_SUB;
            OP_AND:  op_alu = ALU_AND;
            OP_OR:   op_alu = ALU_OR;
            default: op_alu = ALU_ADD;
        endcase
        op_imm = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
        op_mem = (op_q == OP_LW) || (op_q == OP_SW);
    end

    // A ready in the limit cycle still completes the access normally.
    assign timeout = (WAIT_MAX != 0) && (wait_cnt == WAIT_LIMIT) && !mem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (mem_req && !mem_ready && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    // NOTE: every output and state_d is defaulted first, so no path through the
    // case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 5'b00000;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        fault      = 1'b0;
        state      = 3'd0;

        // Outputs are forced quiet while reset is held, even before the first edge.
        if (!rst) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP: begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_LW, OP_SW: begin
                            state_d = S_EXEC;
                        end
                        default: state_d = S_FAULT;
                    endcase
                end
                S_EXEC: begin
                    alu_op  = op_alu;
                    alu_src = op_imm;
                    state_d = op_mem ? S_MEM : S_WB;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                    mem_we  = (op_q == OP_SW);
                    alu_op  = op_alu;
                    alu_src = op_imm;
                    if (mem_ready) begin
                        if (op_q == OP_SW) begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end
                S_WB: begin
                    alu_op     = op_alu;
                    alu_src    = op_imm;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    reg_dst    = !((op_q == OP_ADDI) || (op_q == OP_LW));
                    mem_to_reg = (op_q == OP_LW);
                    state_d    = S_FETCH;
                end
                S_FAULT: begin
                    fault = 1'b1;
                end
                default: state_d = S_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: compares the full output vector each cycle
// against hand-derived expectations for every instruction class, traps and reset.
module tb_multicycle_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    localparam logic [4:0] A_ADD = 5'b00010;
    localparam logic [4:0] A_SUB = 5'b01110;
    localparam logic [4:0] A_AND = 5'b00000;
    localparam logic [4:0] A_OR  = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_we, mem_sel, ir_write, pc_write, alu_src;
    logic [4:0] alu_op;
    logic       reg_dst, reg_write, mem_to_reg, instr_done, fault;
    logic [2:0] state;
    logic [18:0] obs;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl #(.WAIT_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, fault, instr_done, mem_to_reg, reg_write, reg_dst,
                  alu_op, alu_src, pc_write, ir_write, mem_sel, mem_we, mem_req};

    function automatic logic [18:0] ev(input logic [2:0] st, input logic req, input logic we,
                                       input logic sel, input logic irpc, input logic src,
                                       input logic [4:0] aop, input logic dst, input logic rw,
                                       input logic m2r, input logic done, input logic flt);
        return {st, flt, done, m2r, rw, dst, aop, src, irpc, irpc, sel, we, req};
    endfunction

    function automatic logic [18:0] e_fetch(input logic rdy);
        return ev(3'd0, H, L, L, rdy, L, 5'd0, L, L, L, L, L);
    endfunction
    function automatic logic [18:0] e_decode(input logic done);
        return ev(3'd1, L, L, L, L, L, 5'd0, L, L, L, done, L);
    endfunction
    function automatic logic [18:0] e_exec(input logic [4:0] aop, input logic src);
        return ev(3'd2, L, L, L, L, src, aop, L, L, L, L, L);
    endfunction
    function automatic logic [18:0] e_mem(input logic we, input logic [4:0] aop, input logic done);
        return ev(3'd3, H, we, H, L, H, aop, L, L, L, done, L);
    endfunction
    function automatic logic [18:0] e_wb(input logic [4:0] aop, input logic src,
                                         input logic dst, input logic m2r);
        return ev(3'd4, L, L, L, L, src, aop, dst, H, m2r, H, L);
    endfunction
    function automatic logic [18:0] e_fault();
        return ev(3'd5, L, L, L, L, L, 5'd0, L, L, L, L, H);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = H;
        tick();
        tick();
        rst = L;
    endtask

    task automatic test_reset();
        rst = H;
        mem_ready = H;
        opcode = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (obs !== 19'd0) begin
                failures++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, 19'd0);
            end
        end
        rst = L;
        #1;
        checks++;
        if (obs !== e_fetch(H)) begin
            failures++;
            $display("FAIL reset_release: got %b expected %b", obs, e_fetch(H));
        end
    endtask

    task automatic test_add();
        logic [18:0] want [5];
        want = '{e_fetch(H), e_decode(L), e_exec(A_ADD, L), e_wb(A_ADD, L, H, L), e_fetch(H)};
        do_reset();
        opcode = 4'b0001;
        mem_ready = H;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL add[%0d]: got %b expected %b", i, obs, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy  [8];
        logic [18:0] want [8];
        rdy  = '{H, H, H, L, L, H, H, H};
        want = '{e_fetch(H), e_decode(L), e_exec(A_ADD, H), e_mem(L, A_ADD, L),
                 e_mem(L, A_ADD, L), e_mem(L, A_ADD, L), e_wb(A_ADD, H, L, H), e_fetch(H)};
        do_reset();
        opcode = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL lw_wait[%0d]: got %b expected %b", i, obs, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_sw();
        logic        rdy  [6];
        logic [18:0] want [6];
        rdy  = '{H, H, H, L, H, H};
        want = '{e_fetch(H), e_decode(L), e_exec(A_ADD, H), e_mem(H, A_ADD, L),
                 e_mem(H, A_ADD, H), e_fetch(H)};
        do_reset();
        opcode = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL sw[%0d]: got %b expected %b", i, obs, want[i]);
            end
            tick();
        end
    endtask

    // ADDI/SUB/AND/OR then NOP, back to back; opcode is only valid in DECODE.
    task automatic test_back_to_back();
        logic [3:0]  oc [4];
        logic [4:0]  ao [4];
        logic        sr [4];
        logic        ds [4];
        logic [18:0] want [4];
        logic [18:0] nop_want [3];
        oc = '{4'b0010, 4'b0011, 4'b0100, 4'b0101};
        ao = '{A_ADD, A_SUB, A_AND, A_OR};
        sr = '{H, L, L, L};
        ds = '{L, H, H, H};
        do_reset();
        mem_ready = H;
        for (int k = 0; k < 4; k++) begin
            want = '{e_fetch(H), e_decode(L), e_exec(ao[k], sr[k]), e_wb(ao[k], sr[k], ds[k], L)};
            for (int p = 0; p < 4; p++) begin
                opcode = (p == 1) ? oc[k] : 4'hF;
                #1;
                checks++;
                if (obs !== want[p]) begin
                    failures++;
                    $display("FAIL b2b_op%0d[%0d]: got %b expected %b", k, p, obs, want[p]);
                end
                tick();
            end
        end
        nop_want = '{e_fetch(H), e_decode(H), e_fetch(H)};
        for (int p = 0; p < 3; p++) begin
            opcode = (p == 1) ? 4'b0000 : 4'hF;
            #1;
            checks++;
            if (obs !== nop_want[p]) begin
                failures++;
                $display("FAIL nop[%0d]: got %b expected %b", p, obs, nop_want[p]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  codes [4];
        logic [18:0] want;
        int          n;
        codes = '{4'b0110, 4'b0111, 4'b1010, 4'b1111};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            opcode = codes[k];
            n = (k == 1) ? 22 : 4;
            for (int i = 0; i < n; i++) begin
                mem_ready = (i < 2 || i % 3 == 0) ? H : L;
                want = (i == 0) ? e_fetch(H) : (i == 1) ? e_decode(L) : e_fault();
                #1;
                checks++;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL illegal_%b[%0d]: got %b expected %b", codes[k], i, obs, want);
                end
                tick();
            end
            rst = H;
            #1;
            checks++;
            if (obs !== 19'd0) begin
                failures++;
                $display("FAIL illegal_rst_%b: got %b expected %b", codes[k], obs, 19'd0);
            end
            tick();
            rst = L;
            mem_ready = H;
            #1;
            checks++;
            if (obs !== e_fetch(H)) begin
                failures++;
                $display("FAIL illegal_restart_%b: got %b expected %b", codes[k], obs, e_fetch(H));
            end
        end
    endtask

    task automatic test_timeout_fetch();
        logic        rdy_a  [7];
        logic [18:0] want_a [7];
        logic        rdy_b  [6];
        logic [18:0] want_b [6];
        rdy_a  = '{L, L, L, L, L, L, H};
        want_a = '{e_fetch(L), e_fetch(L), e_fetch(L), e_fetch(L), e_fetch(L), e_fault(), e_fault()};
        rdy_b  = '{L, L, L, L, H, H};
        want_b = '{e_fetch(L), e_fetch(L), e_fetch(L), e_fetch(L), e_fetch(H), e_decode(L)};
        do_reset();
        opcode = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy_a[i];
            #1;
            checks++;
            if (obs !== want_a[i]) begin
                failures++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, obs, want_a[i]);
            end
            tick();
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy_b[i];
            #1;
            checks++;
            if (obs !== want_b[i]) begin
                failures++;
                $display("FAIL limit_ready[%0d]: got %b expected %b", i, obs, want_b[i]);
            end
            tick();
        end
    endtask

    // Counter must restart on MEM entry; then a second LW times out in MEM.
    task automatic test_timeout_mem();
        logic        rdy  [21];
        logic [18:0] want [21];
        rdy  = '{L, L, L, H, H, H, L, L, L, L, H, H,
                 H, H, H, L, L, L, L, L, H};
        want = '{e_fetch(L), e_fetch(L), e_fetch(L), e_fetch(H), e_decode(L), e_exec(A_ADD, H),
                 e_mem(L, A_ADD, L), e_mem(L, A_ADD, L), e_mem(L, A_ADD, L), e_mem(L, A_ADD, L),
                 e_mem(L, A_ADD, L), e_wb(A_ADD, H, L, H),
                 e_fetch(H), e_decode(L), e_exec(A_ADD, H),
                 e_mem(L, A_ADD, L), e_mem(L, A_ADD, L), e_mem(L, A_ADD, L), e_mem(L, A_ADD, L),
                 e_mem(L, A_ADD, L), e_fault()};
        do_reset();
        opcode = 4'b1000;
        for (int i = 0; i < 21; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL mem_timeout[%0d]: got %b expected %b", i, obs, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        logic        rdy  [4];
        logic [18:0] want [4];
        rdy  = '{H, H, H, L};
        want = '{e_fetch(H), e_decode(L), e_exec(A_ADD, H), e_mem(L, A_ADD, L)};
        do_reset();
        opcode = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (obs !== want[i]) begin
                failures++;
                $display("FAIL rst_mid[%0d]: got %b expected %b", i, obs, want[i]);
            end
            tick();
        end
        rst = H;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs !== 19'd0) begin
                failures++;
                $display("FAIL rst_mid_hold[%0d]: got %b expected %b", i, obs, 19'd0);
            end
            tick();
        end
        rst = L;
        mem_ready = H;
        #1;
        checks++;
        if (obs !== e_fetch(H)) begin
            failures++;
            $display("FAIL rst_mid_fetch: got %b expected %b", obs, e_fetch(H));
        end
        tick();
        #1;
        checks++;
        if (obs !== e_decode(L)) begin
            failures++;
            $display("FAIL rst_mid_decode: got %b expected %b", obs, e_decode(L));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_back_to_back();
        test_illegal();
        test_timeout_fetch();
        test_timeout_mem();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
